// File: rtl/regfile_scoreboard.sv
// 16-entry register file with a per-register busy scoreboard for pending multi-cycle writes.
// Two combinational read ports with optional same-cycle write forwarding.
module regfile_scoreboard #(
  parameter int DATA_BITS = 8,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           rd_addr_a,
  output logic [DATA_BITS-1:0] rd_data_a,
  output logic                 rd_busy_a,
  input  logic [3:0]           rd_addr_b,
  output logic [DATA_BITS-1:0] rd_data_b,
  output logic                 rd_busy_b,
  input  logic                 wr_en,
  input  logic [3:0]           wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rsv_en,
  input  logic [3:0]           rsv_addr,
  output logic                 rsv_ready,
  output logic [15:0]          busy_mask
);

  logic [DATA_BITS-1:0] regs [16];
  logic [15:0]          busy;
  logic [15:0]          busy_next;
  logic                 rsv_ok;
  logic                 rsv_take;

  // A busy register may be re-reserved in the same cycle its pending write lands.
  assign rsv_ok    = !busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr));
  assign rsv_take  = rsv_en && rsv_ok;
  assign rsv_ready = !reset_n || rsv_ok;
  assign busy_mask = busy;

  // Release on write is applied first so a same-address reservation wins.
  always_comb begin
    busy_next = busy;
    if (wr_en)
      busy_next[wr_addr] = 1'b0;
    if (rsv_take)
      busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
      for (int i = 0; i < 16; i++)
        regs[i] <= '0;
    end else begin
      busy <= busy_next;
      if (wr_en)
        regs[wr_addr] <= wr_data;
    end
  end

  // Outputs are forced to zero during reset so the forwarding path cannot leak wr_data.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_busy_a = busy[rd_addr_a];
    if (BYPASS && wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
      rd_busy_a = rsv_take && (rsv_addr == rd_addr_a);
    end
    if (!reset_n) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    rd_busy_b = busy[rd_addr_b];
    if (BYPASS && wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
      rd_busy_b = rsv_take && (rsv_addr == rd_addr_b);
    end
    if (!reset_n) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: vector table plus hand sequences for reset and sweeps.
// A second instance with forwarding disabled shares all inputs.
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset_n;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic        wr_en, rsv_en;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b, rsv_ready;
  logic [15:0] busy_mask;
  logic [7:0]  nb_data_a, nb_data_b;
  logic        nb_busy_a, nb_busy_b, nb_ready;
  logic [15:0] nb_mask;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard #(.DATA_BITS(8), .BYPASS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .busy_mask(busy_mask)
  );

  regfile_scoreboard #(.DATA_BITS(8), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n),
    .rd_addr_a(rd_addr_a), .rd_data_a(nb_data_a), .rd_busy_a(nb_busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(nb_data_b), .rd_busy_b(nb_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(nb_ready),
    .busy_mask(nb_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [7:0]  exp_a;
    logic        exp_busy_a;
    logic [7:0]  exp_b;
    logic        exp_busy_b;
    logic        exp_ready;
    logic [15:0] exp_mask;
    logic [7:0]  exp_nb_a;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [7:0] sweepVal(input int i);
    return 8'(i * 29 + 7);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                               input logic re, input logic [3:0] rsa,
                               input logic [3:0] ra, input logic [3:0] rb);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rsv_en    = re;
    rsv_addr  = rsa;
    rd_addr_a = ra;
    rd_addr_b = rb;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 4'd3, 4'd3, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1, 16'h0000, 8'h00};
    vecs[1] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd3, 4'd0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 8'hA5};
    vecs[2] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 4'd3, 4'd7, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0080, 8'hA5};
    vecs[3] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 4'd3, 4'd7, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0080, 8'hA5};
    vecs[4] = '{1'b1, 4'd7, 8'h3C, 1'b0, 4'd7, 4'd7, 4'd7, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b1, 16'h0000, 8'h00};
    vecs[5] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 4'd7, 4'd3, 8'h3C, 1'b0, 8'hA5, 1'b0, 1'b1, 16'h0080, 8'h3C};
    vecs[6] = '{1'b1, 4'd7, 8'h11, 1'b1, 4'd7, 4'd7, 4'd7, 8'h11, 1'b1, 8'h11, 1'b1, 1'b1, 16'h0080, 8'h3C};
    vecs[7] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd7, 4'd7, 8'h11, 1'b1, 8'h11, 1'b1, 1'b1, 16'h0080, 8'h11};
    vecs[8] = '{1'b1, 4'd7, 8'h22, 1'b1, 4'd2, 4'd7, 4'd2, 8'h22, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0004, 8'h11};

    // Reset: outputs zero and reservations accepted while asserted.
    applyStimulus(1'b1, 4'd5, 8'h5A, 1'b0, 4'd5, 4'd5, 4'd5);
    reset_n = 1'b0;
    #12;
    checkOutput("reset_rd_data_a", {8'h00, rd_data_a}, 16'h0000);
    checkOutput("reset_rd_busy_a", {15'h0, rd_busy_a}, 16'h0000);
    checkOutput("reset_rsv_ready", {15'h0, rsv_ready}, 16'h0001);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 4'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'(i), 4'(15 - i));
      #2;
      checkOutput($sformatf("post_reset_a[%0d]", i), {7'h0, rd_busy_a, rd_data_a}, 16'h0000);
      checkOutput($sformatf("post_reset_b[%0d]", 15 - i), {7'h0, rd_busy_b, rd_data_b}, 16'h0000);
    end
    checkOutput("post_reset_mask", busy_mask, 16'h0000);

    // Vector table: combinational outputs before the edge, scoreboard after it.
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      applyStimulus(vecs[v].wr_en, vecs[v].wr_addr, vecs[v].wr_data,
                    vecs[v].rsv_en, vecs[v].rsv_addr, vecs[v].ra, vecs[v].rb);
      #2;
      checkOutput($sformatf("v%0d_rd_data_a", v), {8'h00, rd_data_a}, {8'h00, vecs[v].exp_a});
      checkOutput($sformatf("v%0d_rd_busy_a", v), {15'h0, rd_busy_a}, {15'h0, vecs[v].exp_busy_a});
      checkOutput($sformatf("v%0d_rd_data_b", v), {8'h00, rd_data_b}, {8'h00, vecs[v].exp_b});
      checkOutput($sformatf("v%0d_rd_busy_b", v), {15'h0, rd_busy_b}, {15'h0, vecs[v].exp_busy_b});
      checkOutput($sformatf("v%0d_rsv_ready", v), {15'h0, rsv_ready}, {15'h0, vecs[v].exp_ready});
      checkOutput($sformatf("v%0d_nobypass_a", v), {8'h00, nb_data_a}, {8'h00, vecs[v].exp_nb_a});
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_busy_mask", v), busy_mask, vecs[v].exp_mask);
    end

    // r2 is busy from the table; reserve r15, then write r15 to release it.
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 4'd15, 4'd2);
    @(posedge clk);
    #1;
    checkOutput("seq_rsv15_mask", busy_mask, 16'h8004);
    @(negedge clk);
    applyStimulus(1'b1, 4'd15, 8'hFF, 1'b0, 4'd0, 4'd15, 4'd2);
    @(posedge clk);
    #1;
    checkOutput("seq_wr15_mask", busy_mask, 16'h0004);

    // Mid-cycle reset with a forwarding write in flight.
    @(negedge clk);
    applyStimulus(1'b1, 4'd15, 8'h77, 1'b1, 4'd2, 4'd15, 4'd7);
    #2;
    checkOutput("seq_pre_reset_a", {8'h00, rd_data_a}, 16'h0077);
    reset_n = 1'b0;
    #1;
    checkOutput("seq_async_mask", busy_mask, 16'h0000);
    checkOutput("seq_async_a", {7'h0, rd_busy_a, rd_data_a}, 16'h0000);
    checkOutput("seq_async_b", {7'h0, rd_busy_b, rd_data_b}, 16'h0000);
    checkOutput("seq_async_ready", {15'h0, rsv_ready}, 16'h0001);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd15, 4'd7);
    reset_n = 1'b1;
    #2;
    checkOutput("seq_cleared_r15", {8'h00, rd_data_a}, 16'h0000);
    checkOutput("seq_cleared_r7", {8'h00, rd_data_b}, 16'h0000);

    // Fill all registers; port A looks at the mirrored index to catch aliasing.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 4'(i), sweepVal(i), 1'b0, 4'd0, 4'(15 - i), 4'(i));
      #2;
      checkOutput($sformatf("fill_bypass_b[%0d]", i), {8'h00, rd_data_b}, {8'h00, sweepVal(i)});
      checkOutput($sformatf("fill_mirror_a[%0d]", 15 - i), {8'h00, rd_data_a},
                  (15 - i < i) ? {8'h00, sweepVal(15 - i)} : 16'h0000);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'(i), 4'((i * 7 + 3) % 16));
      #2;
      checkOutput($sformatf("sweep_a[%0d]", i), {8'h00, rd_data_a}, {8'h00, sweepVal(i)});
      checkOutput($sformatf("sweep_b[%0d]", (i * 7 + 3) % 16), {8'h00, rd_data_b},
                  {8'h00, sweepVal((i * 7 + 3) % 16)});
      checkOutput($sformatf("sweep_nb_a[%0d]", i), {8'h00, nb_data_a}, {8'h00, sweepVal(i)});
    end
    checkOutput("sweep_mask", busy_mask, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 16-entry general-purpose register file with a per-register busy scoreboard.
- Consumes the write-back value selected by the result multiplexers and feeds the operand-select stage through two combinational read ports (16:1 selection per port).
- The scoreboard tracks registers with an outstanding multi-cycle write (e.g. memory load), so issue logic can stall on read-after-write hazards.

Parameters:
- DATA_BITS, 8, width of each register and of all data ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- rd_addr_a  input  4  read port A register index.
- rd_data_a  output  DATA_BITS  read port A data.
- rd_busy_a  output  1  register rd_addr_a has a pending write.
- rd_addr_b  input  4  read port B register index.
- rd_data_b  output  DATA_BITS  read port B data.
- rd_busy_b  output  1  register rd_addr_b has a pending write.
- wr_en  input  1  write strobe.
- wr_addr  input  4  write register index.
- wr_data  input  DATA_BITS  write data.
- rsv_en  input  1  request to mark rsv_addr busy.
- rsv_addr  input  4  register to reserve.
- rsv_ready  output  1  a reservation of rsv_addr is accepted this cycle.
- busy_mask  output  16  registered scoreboard, bit i = register i busy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all 16 registers = 0; busy_mask = 0.
  - While reset is asserted, rd_data_a/b = 0, rd_busy_a/b = 0, and rsv_ready = 1.
  - Reset asserted mid-operation discards all pending reservations and contents immediately, without waiting for clk.
- Write: on a rising clk with wr_en=1, regs[wr_addr] <= wr_data, then busy[wr_addr] <= 0.
  - Writes to non-busy registers are legal (ordinary ALU write-back).
  - Stored value is visible on the read ports from the next cycle.
- Reservation:
  - rsv_ready = !busy[rsv_addr] || (wr_en && wr_addr==rsv_addr).
  - On a rising clk with rsv_en=1 and rsv_ready=1, busy[rsv_addr] <= 1.
  - rsv_en with rsv_ready=0 is ignored; no state change. The requester holds rsv_en until rsv_ready.
- Simultaneous write and reservation to the same address in one cycle:
  - the data is written and busy ends at 1 (the new reservation wins over the release).
  - Different addresses are updated independently.
- Reads are combinational; no clocked latency.
  - BYPASS=1 and wr_en=1 with wr_addr==rd_addr_x: rd_data_x = wr_data and rd_busy_x = 0, unless rsv_en/rsv_ready also targets the same address, in which case rd_busy_x = 1.
  - Otherwise rd_data_x = regs[rd_addr_x] and rd_busy_x = busy[rd_addr_x].
  - BYPASS=0: rd_data_x = regs[rd_addr_x] and rd_busy_x = busy[rd_addr_x] always.
  - Both ports may address the same register, including the register being written.
- Widths and indices:
  - No arithmetic; all 16 indices are valid.
  - Register 0 is an ordinary register, not hard-wired.
  - No X or Z is ever driven on any output (unlike the tristate demux outputs elsewhere).
- busy_mask reflects registered state only; it does not include same-cycle bypass.

Test Plan:
- Reset then read all 16 indices on both ports -> every rd_data = 0x00, rd_busy = 0, busy_mask = 0x0000.
- Write 0xA5 to r3 with rd_addr_a = 3 in the same cycle:
  - BYPASS=1 -> rd_data_a = 0xA5 that cycle.
  - BYPASS=0 -> rd_data_a = 0x00 that cycle and 0xA5 the next.
- Reserve r7 -> busy_mask = 0x0080, rd_busy_b = 1 for rd_addr_b = 7.
  - Second rsv_en on r7 -> rsv_ready = 0, busy_mask unchanged.
  - Write 0x3C to r7 -> busy_mask = 0x0000, r7 = 0x3C.
- Same cycle: wr r7 = 0x11 and rsv_en r7 (r7 already busy) -> rsv_ready = 1; after the edge r7 = 0x11 and busy_mask bit 7 = 1.
- Reserve r2 and r15, write r15 = 0xFF, then pulse reset_n low between clock edges -> all outputs return to 0 immediately and busy_mask = 0x0000 before the next clk edge.
- Write a distinct value to each of r0..r15, then sweep both read ports with independent addresses -> each port returns the matching value; the wr_addr=15 / rd_addr=0 and wr_addr=0 / rd_addr=15 cases show no aliasing.
